// File: rtl/wb_port_arbiter.sv
// Register-file write-port scheduler: pipeline write-back vs NSRC out-of-band sources,
// round-robin among sources with a starvation guard. Optional counters: WB_PERF_CNT_EN.
module wb_port_arbiter #(
  parameter int NSRC       = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 pipe_we,
  input  logic [4:0]           pipe_addr,
  input  logic [31:0]          pipe_data,
  input  logic [NSRC-1:0]      src_valid,
  input  logic [5*NSRC-1:0]    src_addr,
  input  logic [32*NSRC-1:0]   src_data,
  output logic [NSRC-1:0]      src_ready,
  output logic                 stall_req,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]          cnt_pipe_wr,
  output logic [31:0]          cnt_src_wr,
  output logic [31:0]          cnt_forced
`endif
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [PW-1:0] r_rr_ptr;
  logic [3:0]    r_wait_cnt;

  logic          w_any_src;
  logic          w_pipe_act;
  logic          w_forced;
  logic          w_src_gnt;
  logic          w_pipe_gnt;
  logic          w_found;
  logic [PW-1:0] w_pick;
  logic [PW-1:0] w_rr_next;
  logic [4:0]    w_sel_addr;
  logic [31:0]   w_sel_data;

  // Rotating search starting at r_rr_ptr; r_rr_ptr only ever holds values < NSRC.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 0; k < NSRC; k++) begin
      idx = (int'(r_rr_ptr) + k) % NSRC;
      if (!w_found && src_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = PW'(idx);
      end
    end
  end

  assign w_rr_next  = PW'((int'(w_pick) + 1) % NSRC);
  assign w_sel_addr = src_addr[int'(w_pick)*5 +: 5];
  assign w_sel_data = src_data[int'(w_pick)*32 +: 32];

  assign w_any_src  = w_found;
  assign w_pipe_act = pipe_we & ~stall & (pipe_addr != 5'd0);
  assign w_forced   = (r_wait_cnt == 4'(STARVE_MAX)) & w_any_src;
  assign w_src_gnt  = w_forced | (~w_pipe_act & w_any_src);
  assign w_pipe_gnt = ~w_forced & w_pipe_act;

  assign src_ready  = (w_src_gnt && !rst) ? (NSRC'(1) << w_pick) : '0;
  assign stall_req  = w_forced & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= 5'd0;
      rf_wdata   <= 32'd0;
      r_rr_ptr   <= '0;
      r_wait_cnt <= 4'd0;
    end else begin
      rf_we <= 1'b0;
      if (w_src_gnt) begin
        r_rr_ptr   <= w_rr_next;
        r_wait_cnt <= 4'd0;
        // A source targeting $0 still completes its handshake but writes nothing.
        if (w_sel_addr != 5'd0) begin
          rf_we    <= 1'b1;
          rf_waddr <= w_sel_addr;
          rf_wdata <= w_sel_data;
        end
      end else begin
        if (w_pipe_gnt) begin
          rf_we    <= 1'b1;
          rf_waddr <= pipe_addr;
          rf_wdata <= pipe_data;
        end
        if (!w_any_src)
          r_wait_cnt <= 4'd0;
        else if (r_wait_cnt != 4'(STARVE_MAX))
          r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_pipe_wr <= 32'd0;
      cnt_src_wr  <= 32'd0;
      cnt_forced  <= 32'd0;
    end else begin
      if (w_pipe_gnt)
        cnt_pipe_wr <= cnt_pipe_wr + 32'd1;
      if (w_src_gnt && (w_sel_addr != 5'd0))
        cnt_src_wr <= cnt_src_wr + 32'd1;
      if (w_forced)
        cnt_forced <= cnt_forced + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the grant rules.
module tb_wb_port_arbiter;
  localparam int NSRC       = 2;
  localparam int STARVE_MAX = 4;

  logic                clk, rst, stall, pipe_we;
  logic [4:0]          pipe_addr;
  logic [31:0]         pipe_data;
  logic [NSRC-1:0]     src_valid;
  logic [5*NSRC-1:0]   src_addr;
  logic [32*NSRC-1:0]  src_data;
  logic [NSRC-1:0]     src_ready;
  logic                stall_req, rf_we;
  logic [4:0]          rf_waddr;
  logic [31:0]         rf_wdata;

  wb_port_arbiter #(.NSRC(NSRC), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
    .pipe_data(pipe_data), .src_valid(src_valid), .src_addr(src_addr), .src_data(src_data),
    .src_ready(src_ready), .stall_req(stall_req), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  // reference model state
  int          m_rr, m_wait;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_known;
  logic [NSRC-1:0] e_ready;
  logic        e_stall;
  int          e_g;
  bit          e_gp;

  // observed
  logic [NSRC-1:0] o_ready;
  logic        o_stall, o_we;
  logic [4:0]  o_addr;
  logic [31:0] o_data;

  task automatic model_reset();
    m_rr = 0; m_wait = 0; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_known = 1'b1;
  endtask

  task automatic model_eval();
    bit any, pact;
    any  = (src_valid != '0);
    pact = pipe_we && !stall && (pipe_addr != 5'd0);
    e_g = -1; e_gp = 1'b0; e_stall = 1'b0; e_ready = '0;
    if (m_wait == STARVE_MAX && any) e_stall = 1'b1;
    if (e_stall || (!pact && any)) begin
      for (int k = 0; k < NSRC; k++)
        if (e_g < 0 && src_valid[(m_rr + k) % NSRC]) e_g = (m_rr + k) % NSRC;
      e_ready[e_g] = 1'b1;
    end else if (pact) e_gp = 1'b1;
  endtask

  task automatic model_commit();
    bit any;
    logic [4:0] a;
    any = (src_valid != '0);
    if (e_g >= 0) begin
      m_rr = (e_g + 1) % NSRC;
      m_wait = 0;
      a = src_addr[e_g*5 +: 5];
      if (a != 5'd0) begin
        m_we = 1'b1; m_addr = a; m_data = src_data[e_g*32 +: 32]; m_known = 1'b1;
      end else begin
        m_we = 1'b0; m_known = 1'b0;
      end
    end else begin
      if (e_gp) begin
        m_we = 1'b1; m_addr = pipe_addr; m_data = pipe_data; m_known = 1'b1;
      end else m_we = 1'b0;
      m_wait = any ? ((m_wait + 1 > STARVE_MAX) ? STARVE_MAX : m_wait + 1) : 0;
    end
  endtask

  // Called at posedge+1; applies one cycle of inputs, ends at the next posedge+1.
  task automatic step(input logic st, input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                      input logic [NSRC-1:0] sv, input logic [5*NSRC-1:0] sa,
                      input logic [32*NSRC-1:0] sd);
    stall = st; pipe_we = pw; pipe_addr = pa; pipe_data = pd;
    src_valid = sv; src_addr = sa; src_data = sd;
    #3;
    model_eval();
    o_ready = src_ready; o_stall = stall_req;
    @(posedge clk);
    model_commit();
    #1;
    o_we = rf_we; o_addr = rf_waddr; o_data = rf_wdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; pipe_we = 1'b1; pipe_addr = 5'd5; pipe_data = 32'h1;
    src_valid = 2'b11; src_addr = '0; src_data = '0;
    #2;
    n_vec++; if (src_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b want=00", src_ready); end
    n_vec++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b want=0", stall_req); end
    @(posedge clk); @(posedge clk); #1;
    n_vec++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rf got=%b/%0d/%h want=0/0/0", rf_we, rf_waddr, rf_wdata); end
    src_valid = '0; pipe_we = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_pipe_only();
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 2'b00, '0, '0);
    n_vec++; if (o_ready !== 2'b00) begin n_fail++; $display("FAIL pipe_ready got=%b want=00", o_ready); end
    n_vec++; if (o_we !== 1'b1 || o_addr !== 5'd5 || o_data !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL pipe_write got=%b/%0d/%h want=1/5/deadbeef", o_we, o_addr, o_data); end
  endtask

  task automatic test_zero_filter();
    step(1'b0, 1'b1, 5'd0, 32'h5A5A, 2'b10, {5'd7, 5'd0}, {32'h11, 32'h0});
    n_vec++; if (o_ready !== 2'b10) begin n_fail++; $display("FAIL zero_ready got=%b want=10", o_ready); end
    n_vec++; if (o_we !== 1'b1 || o_addr !== 5'd7 || o_data !== 32'h11) begin
      n_fail++; $display("FAIL zero_write got=%b/%0d/%h want=1/7/11", o_we, o_addr, o_data); end
  endtask

  task automatic test_round_robin();
    logic [NSRC-1:0] want;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0, 2'b11, {5'd4, 5'd3}, {32'hBBBB0000 + 32'(c), 32'hAAAA0000 + 32'(c)});
      want = (c % 2 == 0) ? 2'b01 : 2'b10;
      n_vec++; if (o_ready !== want) begin n_fail++; $display("FAIL rr_ready c=%0d got=%b want=%b", c, o_ready, want); end
      n_vec++; if (o_we !== 1'b1 || o_addr !== ((c % 2 == 0) ? 5'd3 : 5'd4)) begin
        n_fail++; $display("FAIL rr_write c=%0d got=%b/%0d", c, o_we, o_addr); end
    end
  endtask

  task automatic test_starvation();
    logic [NSRC-1:0] wr;
    logic [4:0] wa;
    logic [31:0] wd, pd;
    step(1'b0, 1'b0, 5'd0, 32'h0, 2'b00, '0, '0);
    for (int c = 0; c < 6; c++) begin
      pd = (c < 4) ? 32'h100 + 32'(c) : 32'h104;
      step(1'b0, 1'b1, 5'd9, pd, (c <= 4) ? 2'b01 : 2'b00, {5'd0, 5'd12}, {32'h0, 32'hC0FFEE});
      wr = (c == 4) ? 2'b01 : 2'b00;
      wa = (c == 4) ? 5'd12 : 5'd9;
      wd = (c == 4) ? 32'hC0FFEE : pd;
      n_vec++; if (o_ready !== wr || o_stall !== (c == 4)) begin
        n_fail++; $display("FAIL starve_gnt c=%0d got=%b/%b want=%b/%b", c, o_ready, o_stall, wr, c == 4); end
      n_vec++; if (o_we !== 1'b1 || o_addr !== wa || o_data !== wd) begin
        n_fail++; $display("FAIL starve_write c=%0d got=%b/%0d/%h want=1/%0d/%h", c, o_we, o_addr, o_data, wa, wd); end
    end
  endtask

  task automatic test_stall();
    step(1'b1, 1'b1, 5'd6, 32'h66, 2'b00, '0, '0);
    n_vec++; if (o_we !== 1'b0 || o_ready !== 2'b00 || o_stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_idle got we=%b rdy=%b sr=%b want 0/00/0", o_we, o_ready, o_stall); end
    step(1'b1, 1'b1, 5'd6, 32'h66, 2'b10, {5'd8, 5'd0}, {32'h88, 32'h0});
    n_vec++; if (o_ready !== 2'b10 || o_we !== 1'b1 || o_addr !== 5'd8 || o_data !== 32'h88) begin
      n_fail++; $display("FAIL stall_src got rdy=%b we=%b %0d/%h want 10 1 8/88", o_ready, o_we, o_addr, o_data); end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 5'd20, 32'h55, 2'b00, '0, '0);
    pipe_we = 1'b0; src_valid = 2'b10; src_addr = {5'd21, 5'd0}; src_data = {32'h77, 32'h0};
    #2;
    n_vec++; if (src_ready !== 2'b10) begin n_fail++; $display("FAIL arst_pre got=%b want=10", src_ready); end
    rst = 1'b1;
    #1;
    n_vec++; if (rf_we !== 1'b0 || src_ready !== 2'b00) begin
      n_fail++; $display("FAIL arst_now got we=%b rdy=%b want 0/00", rf_we, src_ready); end
    @(posedge clk); #1;
    n_vec++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL arst_nowrite got=%b want=0", rf_we); end
    rst = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 5'd0, 32'h0, 2'b11, {5'd21, 5'd22}, {32'h77, 32'h66});
    n_vec++; if (o_ready !== 2'b01 || o_we !== 1'b1 || o_addr !== 5'd22 || o_data !== 32'h66) begin
      n_fail++; $display("FAIL arst_after got rdy=%b we=%b %0d/%h want 01 1 22/66", o_ready, o_we, o_addr, o_data); end
  endtask

  task automatic test_random();
    logic [NSRC-1:0]   sv;
    logic [5*NSRC-1:0] sa;
    logic [32*NSRC-1:0] sd;
    logic st, pw;
    logic [4:0] pa;
    logic [31:0] pd;
    bit hold;
    sv = '0; sa = '0; sd = '0; hold = 1'b0; st = 1'b0; pw = 1'b0; pa = '0; pd = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NSRC; i++)
        if (!sv[i] && $urandom_range(0, 2) == 0) begin
          sv[i] = 1'b1;
          sa[i*5 +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
          sd[i*32 +: 32] = $urandom;
        end
      if (!hold) begin
        st = ($urandom_range(0, 7) == 0);
        pw = ($urandom_range(0, 3) != 0);
        pa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        pd = $urandom;
      end
      step(st, pw, pa, pd, sv, sa, sd);
      n_vec++; if (o_ready !== e_ready || o_stall !== e_stall) begin
        n_fail++; $display("FAIL rand_gnt c=%0d got=%b/%b want=%b/%b", c, o_ready, o_stall, e_ready, e_stall); end
      n_vec++; if (o_we !== m_we || (m_known && (o_addr !== m_addr || o_data !== m_data))) begin
        n_fail++; $display("FAIL rand_rf c=%0d got=%b/%0d/%h want=%b/%0d/%h", c, o_we, o_addr, o_data, m_we, m_addr, m_data); end
      sv = sv & ~o_ready;
      hold = o_stall;
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_pipe_only();
    test_zero_filter();
    test_round_robin();
    test_starvation();
    test_stall();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
